jt49_dcadd: RTL and testbench

JT49_DCADD -- requirements
Module: jt49_dcadd

---
 rtl/jt49_pkg.sv | 23 ++
 rtl/jt49_dcadd_ramp.sv | 54 +++++
 rtl/jt49_dcadd.sv | 125 ++++++++++++
 tb/tb_jt49_dcadd.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/jt49_pkg.sv
// Shared state encoding, ramp opcodes and bias midpoint for jt49_dcadd.
package jt49_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        RUN  = 2'd2,
        FALL = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_UP,
        OP_DN,
        OP_MID
    } op_t;

    function automatic int unsigned mid_val(input int sw, input int rw);
        return 32'd1 << (sw - 1 + rw);
    endfunction

endpackage

// File: rtl/jt49_dcadd_ramp.sv
// Bias accumulator with clamped up/down ramping and end-of-ramp flags.
module jt49_dcadd_ramp
    import jt49_pkg::*;
#(
    parameter int sw    = 8,
    parameter int rw    = 10,
    parameter int RSTEP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  op_t              op,
    output logic [sw+rw-1:0] bnx,
    output logic             rise_done,
    output logic             fall_done
);

    localparam int          BW   = sw + rw;
    localparam int unsigned MIDI = mid_val(sw, rw);
    localparam logic [BW-1:0] MID  = MIDI[BW-1:0];
    localparam logic [BW:0]   STEP = (BW+1)'(RSTEP);

    logic [BW-1:0] bacc;
    logic [BW-1:0] up_v;
    logic [BW-1:0] dn_v;
    logic [BW:0]   up_s;

    always_comb begin
        up_s = {1'b0, bacc} + STEP;
        up_v = (up_s >= {1'b0, MID}) ? MID : up_s[BW-1:0];
        dn_v = ({1'b0, bacc} <= STEP) ? '0 : bacc - STEP[BW-1:0];
        rise_done = (up_v == MID);
        fall_done = (dn_v == '0);
    end

    always_comb begin
        bnx = bacc;
        unique case (op)
            OP_CLR:  bnx = '0;
            OP_UP:   bnx = up_v;
            OP_DN:   bnx = dn_v;
            OP_MID:  bnx = MID;
            default: bnx = bacc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            bacc <= '0;
        else if (cen)
            bacc <= bnx;
    end

endmodule

// File: rtl/jt49_dcadd.sv
// DAC bias ramp: fades a midscale offset in/out around the audio path.
// Define JT49_DCADD_DITHER_EN for error-feedback rounding of the ramp.
module jt49_dcadd
    import jt49_pkg::*;
#(
    parameter int sw    = 8,
    parameter int rw    = 10,
    parameter int RSTEP = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic                 mute,
    input  logic signed [sw-1:0] din,
    output logic        [sw-1:0] dout,
    output logic                 ready
);

    localparam logic [sw:0] HALF = (sw+1)'(1) << (sw - 1);

    state_t           st;
    state_t           st_nx;
    op_t              op;
    logic [sw+rw-1:0] bnx;
    logic             rise_done;
    logic             fall_done;
    logic [sw:0]      rsum;
    logic [sw-1:0]    run_v;
    logic [sw-1:0]    ramp_v;
    logic [sw-1:0]    dnx;

    jt49_dcadd_ramp #(
        .sw   (sw),
        .rw   (rw),
        .RSTEP(RSTEP)
    ) u_ramp (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .op       (op),
        .bnx      (bnx),
        .rise_done(rise_done),
        .fall_done(fall_done)
    );

    // Reversals hold bacc for one cen so the ramp turns without a jump.
    always_comb begin
        st_nx = st;
        op    = OP_HOLD;
        unique case (st)
            IDLE: begin
                op = OP_CLR;
                if (!mute) st_nx = RISE;
            end
            RISE: begin
                if (mute) begin
                    st_nx = FALL;
                end else begin
                    op = OP_UP;
                    if (rise_done) st_nx = RUN;
                end
            end
            RUN: begin
                op = OP_MID;
                if (mute) st_nx = FALL;
            end
            FALL: begin
                if (!mute) begin
                    st_nx = RISE;
                end else begin
                    op = OP_DN;
                    if (fall_done) st_nx = IDLE;
                end
            end
            default: st_nx = IDLE;
        endcase
    end

    always_comb begin
        rsum  = {din[sw-1], din} + HALF;
        run_v = rsum[sw] ? '0 : rsum[sw-1:0];
    end

`ifdef JT49_DCADD_DITHER_EN
    logic [rw-1:0]    err;
    logic [rw-1:0]    err_nx;
    logic [sw+rw-1:0] dsum;

    always_comb begin
        dsum   = bnx + {{sw{1'b0}}, err};
        ramp_v = dsum[sw+rw-1:rw];
        err_nx = (st_nx == RUN || st_nx == IDLE) ? '0 : dsum[rw-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            err <= '0;
        else if (cen)
            err <= err_nx;
    end
`else
    assign ramp_v = bnx[sw+rw-1:rw];
`endif

    always_comb begin
        dnx = ramp_v;
        if (st == RUN)
            dnx = run_v;
        else if (st == IDLE)
            dnx = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= IDLE;
            dout  <= '0;
            ready <= 1'b0;
        end else if (cen) begin
            st    <= st_nx;
            dout  <= dnx;
            ready <= (st_nx == RUN);
        end
    end

endmodule

// File: tb/tb_jt49_dcadd.sv
// Self-checking bench for jt49_dcadd against a behavioural bias-ramp model.
module tb_jt49_dcadd;

    localparam int SW  = 8;
    localparam int RW  = 10;
`ifdef JT49_DCADD_DITHER_EN
    localparam int R    = 3;
    localparam bit DITH = 1'b1;
    localparam int REV  = 120;
`else
    localparam int R    = 1024;
    localparam bit DITH = 1'b0;
    localparam int REV  = 40;
`endif
    localparam int MID = 1 << (SW - 1 + RW);
    localparam int LIM = 2 * MID / R + 20;

    logic              clk  = 1'b0;
    logic              rst  = 1'b1;
    logic              cen  = 1'b0;
    logic              mute = 1'b1;
    logic signed [7:0] din  = '0;
    logic        [7:0] dout;
    logic              ready;

    jt49_dcadd #(
        .sw   (SW),
        .rw   (RW),
        .RSTEP(R)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .mute (mute),
        .din  (din),
        .dout (dout),
        .ready(ready)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef enum {M_SILENT, M_UP, M_ON, M_DOWN} mode_e;

    mode_e md;
    int    b;
    int    e;
    int    xd;
    bit    xr;
    int    tests;
    int    fails;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output while ramping: integer part of the bias, optionally with
    // the previous fractional remainder carried in.
    task automatic ramp_out(output int o);
        int s;
        if (DITH) begin
            s = b + e;
            o = s / (1 << RW);
            e = (md == M_ON || md == M_SILENT) ? 0 : s % (1 << RW);
        end else begin
            o = b / (1 << RW);
        end
    endtask

    task automatic model(input bit m, input int d);
        case (md)
            M_SILENT: begin
                xd = 0; b = 0; e = 0;
                if (!m) md = M_UP;
            end
            M_ON: begin
                xd = d + 128;
                if (xd < 0) xd = 0;
                if (xd > 255) xd = 255;
                if (m) md = M_DOWN;
            end
            M_UP: begin
                if (m) md = M_DOWN;
                else begin
                    b = (b + R > MID) ? MID : b + R;
                    if (b == MID) md = M_ON;
                end
                ramp_out(xd);
            end
            M_DOWN: begin
                if (!m) md = M_UP;
                else begin
                    b = (b - R < 0) ? 0 : b - R;
                    if (b == 0) md = M_SILENT;
                end
                ramp_out(xd);
            end
        endcase
        xr = (md == M_ON);
    endtask

    task automatic step(input bit c, input bit m, input logic signed [7:0] d);
        cen  = c;
        mute = m;
        din  = d;
        if (c) model(m, int'(d));
        @(posedge clk);
        #1;
        chk("dout", dout, xd);
        chk("ready", ready, xr);
    endtask

    task automatic do_rst(input bit c);
        rst = 1'b1;
        cen = c;
        md = M_SILENT; b = 0; e = 0; xd = 0; xr = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_ready", ready, 0);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int prev;
        tests = 0;
        fails = 0;
        md = M_SILENT; b = 0; e = 0; xd = 0; xr = 1'b0;

        do_rst(1'b0);
        do_rst(1'b0);

        // Ramp up to bias 60, then reset mid-ramp
        prev = 0;
        for (int i = 0; i < LIM && (b >> RW) < 60; i++) begin
            step(1'b1, 1'b0, 8'($urandom));
            chk("rise_step", (dout == prev || dout == prev + 1), 1);
            prev = int'(dout);
        end
        chk("bias60", b >> RW, 60);
        do_rst(1'b1);

        // Short ramp then mute back down to IDLE
        for (int i = 0; i < LIM && (b >> RW) < 5; i++)
            step(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < LIM && md != M_SILENT; i++)
            step(1'b1, 1'b1, 8'($urandom));
        chk("idle_dout", dout, 0);
        chk("idle_ready", ready, 0);
        repeat (8) step(1'($urandom), 1'b1, 8'($urandom));

        // Full ramp from IDLE into RUN
        n = 0;
        prev = int'(dout);
        for (int i = 0; i < LIM; i++) begin
            step(1'b1, 1'b0, 8'($urandom));
            n++;
            chk("ramp_step", (dout == prev || dout == prev + 1), 1);
            prev = int'(dout);
            if (ready) break;
        end
        chk("ready_cen", n, 1 + (MID + R - 1) / R);
        chk("run_bias", b, MID);
        chk("run_ready", ready, 1);

        // RUN: offset and saturation corners, hold while cen low
        step(1'b1, 1'b0, -8'sd128);
        chk("run_lo", dout, 0);
        step(1'b1, 1'b0, 8'sd0);
        chk("run_mid", dout, 128);
        step(1'b1, 1'b0, 8'sd127);
        chk("run_hi", dout, 255);
        step(1'b0, 1'b0, -8'sd50);
        step(1'b0, 1'b0, 8'sd17);
        chk("hold", dout, 255);
        repeat (200) step(($urandom % 4) != 0, 1'b0, 8'($urandom));

        // Mute from RUN, fall to REV, reverse back up without a jump
        step(1'b1, 1'b0, 8'sd0);
        step(1'b1, 1'b1, 8'sd0);
        chk("fall_start", dout, 128);
        prev = int'(dout);
        for (int i = 0; i < LIM && (b >> RW) > REV; i++) begin
            step(1'b1, 1'b1, 8'sd0);
            chk("fall_step", (dout == prev || dout == prev - 1), 1);
            chk("fall_ready", ready, 0);
            prev = int'(dout);
        end
        step(1'b1, 1'b0, 8'sd0);
        chk("rev_hold", dout, (b + e) >> RW);
        chk("rev_turn", (dout == prev || dout == prev - 1), 1);
        prev = int'(dout);
        for (int i = 0; i < LIM && !ready; i++) begin
            step(($urandom % 8) != 0, 1'b0, 8'sd0);
            chk("back_step", (dout == prev || dout == prev + 1), 1);
            prev = int'(dout);
        end
        chk("back_ready", ready, 1);
        step(1'b1, 1'b0, -8'sd5);
        chk("back_run", dout, 123);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
